// File: rtl/split_sum_recover_pkg.sv
// Shared types for the split-sum recovery stage: word width, FSM states, word type.
package e8_pkg;
  localparam int W = 12;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} rec_state_t;
  typedef logic [W-1:0] word_t;
endpackage

// File: rtl/split_sum_recover_if.sv
// Request/response handshake bundle between the split-sum producer and the recovery stage.
interface split_sum_recover_if;
  import e8_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_a;
  word_t in_b;
  word_t in_y;
  logic  out_valid;
  logic  out_ready;
  word_t out_x;
  logic  out_err;

  modport master (
    output in_valid, in_a, in_b, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_y, out_ready,
    output in_ready, out_valid, out_x, out_err
  );
endinterface

// File: rtl/split_sum_recover_borrow_stage.sv
// One (W+1)-bit subtract-with-borrow step, shared by the low and high halves.
module sub_borrow_stage
  import e8_pkg::*;
(
  input  word_t        a,
  input  word_t        b,
  input  logic         bin,
  output logic [W:0]   diff,
  output logic         bout
);
  assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign bout = diff[W];
endmodule

// File: rtl/split_sum_recover.sv
// Recovers x = {a,b} - y over two cycles (low half, then high half with borrow)
// and flags results that fall outside 0..2^W-1.
module split_sum_recover
  import e8_pkg::*;
(
  input logic                clk,
  input logic                rst,
  split_sum_recover_if.slave bus
);
  rec_state_t state, state_nxt;

  word_t      a_q, b_q, y_q, x_q;
  logic       borrow_q, err_q;

  word_t      op_a, op_b;
  logic       op_bin;
  logic [W:0] diff;
  logic       bout;

  // Single subtractor: LO computes b - y, HI computes a - borrow.
  assign op_a   = (state == HI) ? a_q : b_q;
  assign op_b   = (state == HI) ? '0  : y_q;
  assign op_bin = (state == HI) ? borrow_q : 1'b0;

  sub_borrow_stage u_stage (
    .a    (op_a),
    .b    (op_b),
    .bin  (op_bin),
    .diff (diff),
    .bout (bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = LO;
      LO:   state_nxt = HI;
      HI:   state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      x_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.in_a;
          b_q <= bus.in_b;
          y_q <= bus.in_y;
        end
        LO: begin
          x_q      <= diff[W-1:0];
          borrow_q <= bout;
        end
        // Any nonzero high part means s < y (wrapped) or x >= 2^W.
        HI:   err_q <= |diff;
        DONE: ;
      endcase
    end
  end

  assign bus.out_x   = x_q;
  assign bus.out_err = err_q;
endmodule

// File: tb/tb_split_sum_recover.sv
// Directed and sweep bench for split_sum_recover with random output backpressure.
module tb_split_sum_recover;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  split_sum_recover_if bus ();

  split_sum_recover dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic run_txn(input logic [11:0] a, input logic [11:0] b, input logic [11:0] y,
                         input logic [11:0] ex, input logic ee, input int stall);
    check("idle_ready", {15'd0, bus.in_ready}, 16'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_y = y;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = 12'($urandom);
    bus.in_b = 12'($urandom);
    bus.in_y = 12'($urandom);
    check("lo_ready", {15'd0, bus.in_ready}, 16'd0);
    check("lo_valid", {15'd0, bus.out_valid}, 16'd0);
    @(negedge clk);
    check("hi_valid", {15'd0, bus.out_valid}, 16'd0);
    @(negedge clk);
    check("done_valid", {15'd0, bus.out_valid}, 16'd1);
    check("out_x", {4'd0, bus.out_x}, {4'd0, ex});
    check("out_err", {15'd0, bus.out_err}, {15'd0, ee});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", {15'd0, bus.out_valid}, 16'd1);
      check("hold_x", {4'd0, bus.out_x}, {4'd0, ex});
      check("hold_err", {15'd0, bus.out_err}, {15'd0, ee});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_valid", {15'd0, bus.out_valid}, 16'd0);
  endtask

  initial begin
    logic [12:0] s;
    logic [11:0] xv;
    logic [11:0] yv;
    passed = 0;
    total  = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // Asynchronous reset, asserted between clock edges.
    #7 rst = 1'b1;
    #1;
    check("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_ready", {15'd0, bus.in_ready}, 16'd1);
    check("rst_x", {4'd0, bus.out_x}, 16'd0);
    check("rst_err", {15'd0, bus.out_err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(12'h000, 12'h008, 12'h003, 12'h005, 1'b0, 0);  // basic
    run_txn(12'h001, 12'hFFD, 12'hFFE, 12'hFFF, 1'b0, 2);  // borrow from high word
    run_txn(12'h000, 12'h002, 12'h003, 12'hFFF, 1'b1, 1);  // negative, a=0 with borrow
    run_txn(12'h002, 12'h000, 12'h000, 12'h000, 1'b1, 0);  // too large
    run_txn(12'h000, 12'h123, 12'h000, 12'h123, 1'b0, 0);  // y=0
    run_txn(12'h001, 12'h0AB, 12'h000, 12'h0AB, 1'b1, 0);  // y=0, a!=0
    run_txn(12'h000, 12'h555, 12'h555, 12'h000, 1'b0, 0);  // b=y

    // New request held during the DONE handshake must wait for the next IDLE cycle.
    bus.in_a = 12'h000; bus.in_b = 12'h008; bus.in_y = 12'h003; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("c1_x", {4'd0, bus.out_x}, 16'h005);
    bus.in_a = 12'h000; bus.in_b = 12'h100; bus.in_y = 12'h001; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("c_idle_ready", {15'd0, bus.in_ready}, 16'd1);
    check("c_idle_valid", {15'd0, bus.out_valid}, 16'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("c_lo_ready", {15'd0, bus.in_ready}, 16'd0);
    @(negedge clk);
    check("c_hi_valid", {15'd0, bus.out_valid}, 16'd0);
    @(negedge clk);
    check("c_done_valid", {15'd0, bus.out_valid}, 16'd1);
    check("c2_x", {4'd0, bus.out_x}, 16'h0FF);
    check("c2_err", {15'd0, bus.out_err}, 16'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Sweep with random backpressure; one transaction is aborted by reset in HI.
    for (int i = 0; i < 4096; i++) begin
      yv = 12'(i);
      xv = 12'(i + 1);
      s  = {1'b0, xv} + {1'b0, yv};
      if (i == 2048) begin
        bus.in_a = 12'(s >> 12); bus.in_b = s[11:0]; bus.in_y = yv; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
        check("mid_rst_ready", {15'd0, bus.in_ready}, 16'd1);
        check("mid_rst_x", {4'd0, bus.out_x}, 16'd0);
        check("mid_rst_err", {15'd0, bus.out_err}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("mid_rst_quiet", {15'd0, bus.out_valid}, 16'd0);
        end
      end
      run_txn(12'(s >> 12), s[11:0], yv, xv, 1'b0, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
